int_controller: RTL and testbench
=================================

# int_controller

Prioritised interrupt controller on MCLK, between the peripheral interrupt outputs and the CPU's interrupt-entry sequencer. It is directly downstream of TimerA. It collects level-sensitive requests, including TimerA's TAxINT0/TAxINT1. It arbitrates the highest-priority enabled request, raises IRQ to the CPU, and on CPU acknowledge latches the vector-table address. For single-source interrupts it also pulses a per-source clear, for example TAxCLR0 back into TimerA.

## Interface
- SRC_COUNT, 15: number of request inputs; index i maps to vector address VECTOR_BASE + 2*i. Higher index means higher priority.
- VECTOR_BASE, 16'hFFE0: address of the vector for source 0. VECTOR_BASE + 2*(SRC_COUNT-1) must be below 16'hFFFE, the reset vector.
- SINGLE_SRC_MASK, 15'h0200: set bit i means source i is auto-cleared on acknowledge.
- NMI_MASK, 15'h6000: set bit i means source i ignores GIE (non-maskable).

Ports (one clock; reset is synchronous and active-high):
- MCLK, input, 1: clock.
- reset, input, 1: synchronous, active-high.
- IntReq, input, SRC_COUNT: level requests, already AND-ed with the peripheral enables.
- GIE, input, 1: SR.GIE from the CPU.
- INTACK, input, 1: one-cycle pulse from the CPU at the start of interrupt entry.
- IRQ, output, 1: registered request to the CPU.
- IntVector, output, 16: registered vector-table address of the acknowledged source.
- IntClr, output, SRC_COUNT: one-cycle registered clear pulses; only bits set in SINGLE_SRC_MASK can be set.
- ActiveIdx, output, 4: index of the last acknowledged source.

## Operation
- Eligible vector: eligible[i] = IntReq[i] & (GIE | NMI_MASK[i]).
- Winner is the highest set index of the eligible vector. It is combinational and re-evaluated every cycle.
- FSM states are IDLE, REQ, ACK and HOLD. The encoding is free.
- IDLE:
  - Goes to REQ if any eligible bit is set.
  - INTACK is ignored.
- REQ:
  - IRQ = 1.
  - If INTACK = 1 and the eligible vector is non-zero:
    - latch IntVector = VECTOR_BASE + (winner << 1) and ActiveIdx = winner;
    - set IntClr[winner] if SINGLE_SRC_MASK[winner] is set;
    - go to ACK.
  - If the eligible vector becomes zero (request withdrawn or GIE cleared on a maskable source) go to IDLE. This holds even if INTACK is high in the same cycle: no latch, no clear.
  - Otherwise stay in REQ.
- ACK:
  - IRQ = 0; IntClr pulse visible.
  - Unconditionally go to HOLD.
- HOLD:
  - IRQ = 0; IntClr = 0.
  - This one-cycle blanking covers the peripheral flag-clear latency, so the same source cannot re-request.
  - Unconditionally go to IDLE.
- Vector arithmetic is 16-bit and ignores carry out. The low bit of IntVector is always 0.
- IntVector and ActiveIdx hold their value until the next acknowledge.
- Reset values in any state:
  - state IDLE;
  - IRQ = 0;
  - IntVector = 16'hFFFE;
  - IntClr = 0;
  - ActiveIdx = 4'hF.
- Reset aborts a pending IntClr pulse.

## Timing
- Request to IRQ: request eligible in cycle n, IRQ = 1 in cycle n+1.
- INTACK sampled high at the end of cycle m while in REQ:
  - IntVector, ActiveIdx and IntClr are valid in cycle m+1 (ACK); IRQ = 0 from m+1.
  - HOLD in m+2, IDLE in m+3.
  - Earliest re-assertion of IRQ is m+4.
- The winner is taken at the INTACK edge, not at IRQ rise. A higher-priority request arriving while in REQ pre-empts the lower one.
- IntClr is exactly one cycle wide and occurs once per acknowledge.
- Source change from non-single-source to single-source: no clear is generated for the old source.
- GIE changes take effect in the same cycle, because eligibility is evaluated on the current GIE.

## Test plan
- Basic TimerA CCR0 flow:
  - Stimulus: GIE = 1, IntReq = 15'h0200, INTACK pulsed 3 cycles after IRQ rises.
  - Response: IRQ rises 1 cycle after the request. Next cycle: IntVector = 16'hFFF2, ActiveIdx = 9, IntClr = 15'h0200 for exactly one cycle, IRQ = 0 for 3 cycles.
- Priority:
  - Stimulus: IntReq = 15'h0021 (sources 0 and 5), then INTACK.
  - Response: IntVector = 16'hFFEA, ActiveIdx = 5, IntClr = 0 (not single-source).
  - Stimulus: hold the request, then INTACK again after IRQ re-asserts.
  - Response: IntVector = 16'hFFEA again.
- GIE masking and NMI:
  - Stimulus: GIE = 0, IntReq = 15'h0201.
  - Response: IRQ stays 0.
  - Stimulus: add bit 13.
  - Response: IRQ = 1; after INTACK, IntVector = 16'hFFFA.
- Withdrawal race:
  - Stimulus: in REQ, drop IntReq in the same cycle INTACK = 1.
  - Response: IDLE next cycle, IntVector and ActiveIdx unchanged, IntClr = 0.
- Pre-emption:
  - Stimulus: IntReq = 15'h0001 in REQ, raise bit 14 one cycle before INTACK.
  - Response: IntVector = 16'hFFFC, ActiveIdx = 14.
- Reset mid-operation:
  - Stimulus: assert reset during the ACK cycle.
  - Response: next cycle IRQ = 0, IntClr = 0, IntVector = 16'hFFFE, ActiveIdx = 4'hF, FSM in IDLE.

Source files
------------

// File: rtl/int_controller.sv
// Prioritised interrupt controller: arbitrates level requests, raises IRQ,
// latches the vector on acknowledge and pulses per-source clears.
module int_controller #(
    parameter int unsigned SRC_COUNT = 15,
    parameter logic [15:0] VECTOR_BASE = 16'hFFE0,
    parameter logic [SRC_COUNT-1:0] SINGLE_SRC_MASK = 15'h0200,
    parameter logic [SRC_COUNT-1:0] NMI_MASK = 15'h6000
) (
    input  logic                 MCLK,
    input  logic                 reset,
    input  logic [SRC_COUNT-1:0] IntReq,
    input  logic                 GIE,
    input  logic                 INTACK,
    output logic                 IRQ,
    output logic [15:0]          IntVector,
    output logic [SRC_COUNT-1:0] IntClr,
    output logic [3:0]           ActiveIdx
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        ACK  = 2'd2,
        HOLD = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic                 irq_q, irq_d;
    logic [15:0]          vec_q, vec_d;
    logic [SRC_COUNT-1:0] clr_q, clr_d;
    logic [3:0]           idx_q, idx_d;

    logic [SRC_COUNT-1:0] eligible;
    logic                 any_elig;
    logic [3:0]           winner;
    logic [15:0]          win_vec;

    assign eligible = IntReq & ({SRC_COUNT{GIE}} | NMI_MASK);
    assign any_elig = |eligible;

    // Ascending scan so the highest set index wins.
    always_comb begin
        winner = 4'd0;
        for (int i = 0; i < SRC_COUNT; i++) begin
            if (eligible[i]) begin
                winner = 4'(i);
            end
        end
    end

    assign win_vec = VECTOR_BASE + {11'd0, winner, 1'b0};

    always_comb begin
        state_d = state_q;
        vec_d   = vec_q;
        idx_d   = idx_q;
        clr_d   = '0;
        unique case (state_q)
            IDLE: begin
                if (any_elig) begin
                    state_d = REQ;
                end
            end
            REQ: begin
                if (!any_elig) begin
                    state_d = IDLE;
                end else if (INTACK) begin
                    state_d = ACK;
                    vec_d   = win_vec;
                    idx_d   = winner;
                    if (SINGLE_SRC_MASK[winner]) begin
                        clr_d[winner] = 1'b1;
                    end
                end
            end
            ACK: begin
                state_d = HOLD;
            end
            HOLD: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        // IRQ is registered, so it follows the state being entered.
        irq_d = (state_d == REQ);
    end

    always_ff @(posedge MCLK) begin
        if (reset) begin
            state_q <= IDLE;
            irq_q   <= 1'b0;
            vec_q   <= 16'hFFFE;
            clr_q   <= '0;
            idx_q   <= 4'hF;
        end else begin
            state_q <= state_d;
            irq_q   <= irq_d;
            vec_q   <= vec_d;
            clr_q   <= clr_d;
            idx_q   <= idx_d;
        end
    end

    assign IRQ       = irq_q;
    assign IntVector = vec_q;
    assign IntClr    = clr_q;
    assign ActiveIdx = idx_q;

endmodule

// File: tb/tb_int_controller.sv
// Directed bench for int_controller with hand-computed expectations.
module tb_int_controller;

    logic        MCLK;
    logic        reset;
    logic [14:0] IntReq;
    logic        GIE;
    logic        INTACK;
    logic        IRQ;
    logic [15:0] IntVector;
    logic [14:0] IntClr;
    logic [3:0]  ActiveIdx;

    int checks;
    int errors;

    int_controller dut (
        .MCLK      (MCLK),
        .reset     (reset),
        .IntReq    (IntReq),
        .GIE       (GIE),
        .INTACK    (INTACK),
        .IRQ       (IRQ),
        .IntVector (IntVector),
        .IntClr    (IntClr),
        .ActiveIdx (ActiveIdx)
    );

    initial MCLK = 1'b0;
    always #5 MCLK = ~MCLK;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge MCLK);
        #1;
    endtask

    task automatic chk_all(input string tag, input logic irq,
                           input logic [15:0] vec, input logic [14:0] clr,
                           input logic [3:0] idx);
        chk({tag, ".irq"}, 32'(IRQ), 32'(irq));
        chk({tag, ".vec"}, 32'(IntVector), 32'(vec));
        chk({tag, ".clr"}, 32'(IntClr), 32'(clr));
        chk({tag, ".idx"}, 32'(ActiveIdx), 32'(idx));
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        IntReq = '0;
        GIE    = 1'b0;
        INTACK = 1'b0;
        tick();
        tick();
        chk_all("rst", 1'b0, 16'hFFFE, 15'h0, 4'hF);
        reset = 1'b0;
        tick();
        chk("idle_irq", 32'(IRQ), 32'd0);

        // Basic CCR0 flow
        GIE    = 1'b1;
        IntReq = 15'h0200;
        tick();
        chk("b_irq_rise", 32'(IRQ), 32'd1);
        tick();
        tick();
        chk("b_irq_hold", 32'(IRQ), 32'd1);
        INTACK = 1'b1;
        tick();
        chk_all("b_ack", 1'b0, 16'hFFF2, 15'h0200, 4'd9);
        INTACK = 1'b0;
        IntReq = '0;
        tick();
        chk_all("b_hold", 1'b0, 16'hFFF2, 15'h0, 4'd9);
        tick();
        chk("b_idle_irq", 32'(IRQ), 32'd0);
        tick();
        chk("b_idle2_irq", 32'(IRQ), 32'd0);

        // Priority, then re-request
        IntReq = 15'h0021;
        tick();
        chk("p_irq", 32'(IRQ), 32'd1);
        INTACK = 1'b1;
        tick();
        chk_all("p_ack", 1'b0, 16'hFFEA, 15'h0, 4'd5);
        INTACK = 1'b0;
        tick();
        chk("p_hold_irq", 32'(IRQ), 32'd0);
        tick();
        chk("p_idle_irq", 32'(IRQ), 32'd0);
        tick();
        chk("p_rearm_irq", 32'(IRQ), 32'd1);
        INTACK = 1'b1;
        tick();
        chk_all("p_ack2", 1'b0, 16'hFFEA, 15'h0, 4'd5);
        INTACK = 1'b0;
        IntReq = '0;
        tick();
        tick();
        tick();

        // GIE masking and NMI
        GIE    = 1'b0;
        IntReq = 15'h0201;
        tick();
        tick();
        chk("g_masked_irq", 32'(IRQ), 32'd0);
        IntReq = 15'h2201;
        tick();
        chk("g_nmi_irq", 32'(IRQ), 32'd1);
        INTACK = 1'b1;
        tick();
        chk_all("g_ack", 1'b0, 16'hFFFA, 15'h0, 4'd13);
        INTACK = 1'b0;
        IntReq = '0;
        GIE    = 1'b1;
        tick();
        tick();
        tick();

        // Withdrawal race
        IntReq = 15'h0001;
        tick();
        chk("w_irq", 32'(IRQ), 32'd1);
        IntReq = '0;
        INTACK = 1'b1;
        tick();
        chk_all("w_race", 1'b0, 16'hFFFA, 15'h0, 4'd13);
        INTACK = 1'b0;
        IntReq = 15'h0001;
        tick();
        chk("w_idle_rearm", 32'(IRQ), 32'd1);

        // Pre-emption while in REQ
        tick();
        IntReq = 15'h4001;
        tick();
        chk("e_irq", 32'(IRQ), 32'd1);
        INTACK = 1'b1;
        tick();
        chk_all("e_ack", 1'b0, 16'hFFFC, 15'h0, 4'd14);
        INTACK = 1'b0;
        IntReq = '0;
        tick();
        tick();

        // GIE drop withdraws a maskable request
        IntReq = 15'h0001;
        tick();
        chk("m_irq", 32'(IRQ), 32'd1);
        GIE = 1'b0;
        tick();
        chk("m_gie_drop", 32'(IRQ), 32'd0);
        GIE    = 1'b1;
        IntReq = '0;
        tick();

        // Reset during ACK
        IntReq = 15'h0200;
        tick();
        chk("r_irq", 32'(IRQ), 32'd1);
        INTACK = 1'b1;
        tick();
        chk_all("r_ack", 1'b0, 16'hFFF2, 15'h0200, 4'd9);
        INTACK = 1'b0;
        IntReq = '0;
        reset  = 1'b1;
        tick();
        chk_all("r_rst", 1'b0, 16'hFFFE, 15'h0, 4'hF);
        reset  = 1'b0;
        IntReq = 15'h0200;
        tick();
        chk("r_idle_rearm", 32'(IRQ), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
